// File: rtl/csc_pkg.sv
// Shared constants and helpers for the 3x3 colour-space converter.
package csc_pkg;

    // Fixed pipeline depth for data, bypass data, syncs and de.
    localparam int LAT      = 4;

    // Coefficient bank layout: nine matrix entries (row-major), then three offsets.
    localparam int NUM_COEF = 12;

    localparam logic [3:0] ADDR_M00  = 4'd0;
    localparam logic [3:0] ADDR_M01  = 4'd1;
    localparam logic [3:0] ADDR_M02  = 4'd2;
    localparam logic [3:0] ADDR_M10  = 4'd3;
    localparam logic [3:0] ADDR_M11  = 4'd4;
    localparam logic [3:0] ADDR_M12  = 4'd5;
    localparam logic [3:0] ADDR_M20  = 4'd6;
    localparam logic [3:0] ADDR_M21  = 4'd7;
    localparam logic [3:0] ADDR_M22  = 4'd8;
    localparam logic [3:0] ADDR_OFF0 = 4'd9;
    localparam logic [3:0] ADDR_OFF1 = 4'd10;
    localparam logic [3:0] ADDR_OFF2 = 4'd11;

    // Fixed-point encoding of 1.0 for a coefficient of width cw with frac fractional bits.
    function automatic int identity_coef(input int cw, input int frac);
        return (cw > frac) ? (1 << frac) : 0;
    endfunction

endpackage

// File: rtl/csc_matrix_pipe_if.sv
// Pixel stream, sync and coefficient-programming signals of the colour-space converter.
// master drives pixels/coefficients and observes results; slave is the converter.
interface csc_matrix_pipe_if #(
    parameter int DW = 12,
    parameter int CW = 16
) ();

    logic [DW-1:0] din0;
    logic [DW-1:0] din1;
    logic [DW-1:0] din2;
    logic          hsync_in;
    logic          vsync_in;
    logic          de_in;
    logic          bypass;

    logic          coef_wr;
    logic [3:0]    coef_addr;
    logic [CW-1:0] coef_wdata;

    logic [DW-1:0] dout0;
    logic [DW-1:0] dout1;
    logic [DW-1:0] dout2;
    logic          hsync_out;
    logic          vsync_out;
    logic          de_out;
    logic          coef_pending;

    modport master (
        output din0, din1, din2, hsync_in, vsync_in, de_in, bypass,
        output coef_wr, coef_addr, coef_wdata,
        input  dout0, dout1, dout2, hsync_out, vsync_out, de_out, coef_pending
    );

    modport slave (
        input  din0, din1, din2, hsync_in, vsync_in, de_in, bypass,
        input  coef_wr, coef_addr, coef_wdata,
        output dout0, dout1, dout2, hsync_out, vsync_out, de_out, coef_pending
    );

endinterface

// File: rtl/csc_dot3.sv
// One output row of the converter: three signed products (S2), row sum with rounding
// constant and offset (S3), shift/clamp or bypass select into the output register (S4).
module csc_dot3 #(
    parameter int DW   = 12,
    parameter int CW   = 16,
    parameter int FRAC = 12
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [DW-1:0]        i_din0,
    input  logic [DW-1:0]        i_din1,
    input  logic [DW-1:0]        i_din2,
    input  logic signed [CW-1:0] i_m0,
    input  logic signed [CW-1:0] i_m1,
    input  logic signed [CW-1:0] i_m2,
    input  logic signed [DW:0]   i_off,
    input  logic                 i_byp,
    input  logic [DW-1:0]        i_bdin,
    output logic [DW-1:0]        o_dout
);

    localparam int PW = DW + CW + 1;
    localparam int SW = DW + CW + 3;
    localparam logic signed [SW-1:0] C_RND = SW'(1 << (FRAC - 1));
    localparam logic signed [SW-1:0] C_MAX = SW'((1 << DW) - 1);

    logic signed [PW-1:0] w_x0, w_x1, w_x2;
    logic signed [PW-1:0] w_c0, w_c1, w_c2;
    logic signed [PW-1:0] r_p0, r_p1, r_p2;
    logic                 r_byp_s2, r_byp_s3;
    logic [DW-1:0]        r_bdin_s2, r_bdin_s3;
    logic signed [SW-1:0] w_off_sh;
    logic signed [SW-1:0] r_sum;
    logic signed [SW-1:0] w_shift;
    logic [DW-1:0]        w_clamp;
    logic [DW-1:0]        r_dout;

    // Components are unsigned, so a zero sign bit is prepended before the signed multiply.
    assign w_x0 = PW'($signed({1'b0, i_din0}));
    assign w_x1 = PW'($signed({1'b0, i_din1}));
    assign w_x2 = PW'($signed({1'b0, i_din2}));
    assign w_c0 = PW'(i_m0);
    assign w_c1 = PW'(i_m1);
    assign w_c2 = PW'(i_m2);

    // Offset is in output units; scale it up to the fixed-point sum domain.
    assign w_off_sh = SW'(i_off) <<< FRAC;

    // S2: products, bypass flag and bypass data travel alongside.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_p0      <= '0;
            r_p1      <= '0;
            r_p2      <= '0;
            r_byp_s2  <= 1'b0;
            r_bdin_s2 <= '0;
        end else begin
            r_p0      <= w_x0 * w_c0;
            r_p1      <= w_x1 * w_c1;
            r_p2      <= w_x2 * w_c2;
            r_byp_s2  <= i_byp;
            r_bdin_s2 <= i_bdin;
        end
    end

    // S3: row sum plus half-LSB rounding constant plus scaled offset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sum     <= '0;
            r_byp_s3  <= 1'b0;
            r_bdin_s3 <= '0;
        end else begin
            r_sum     <= SW'(r_p0) + SW'(r_p1) + SW'(r_p2) + C_RND + w_off_sh;
            r_byp_s3  <= r_byp_s2;
            r_bdin_s3 <= r_bdin_s2;
        end
    end

    // Arithmetic shift floors, which together with the half-LSB constant gives round-half-up.
    assign w_shift = r_sum >>> FRAC;

    // Saturate to the unsigned output range.
    always_comb begin
        w_clamp = w_shift[DW-1:0];
        if (w_shift[SW-1]) begin
            w_clamp = '0;
        end else if (w_shift > C_MAX) begin
            w_clamp = '1;
        end
    end

    // S4: output register, selecting the untouched component for bypassed pixels.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_dout <= '0;
        end else begin
            r_dout <= r_byp_s3 ? r_bdin_s3 : w_clamp;
        end
    end

    assign o_dout = r_dout;

endmodule

// File: rtl/csc_matrix_pipe.sv
// 3x3 colour-space converter top: double-buffered coefficient banks with frame-start
// commit, input stage, sync/de delay line and three row datapaths.
module csc_matrix_pipe
    import csc_pkg::*;
#(
    parameter int DW   = 12,
    parameter int CW   = 16,
    parameter int FRAC = 12
) (
    input  logic               clk,
    input  logic               rstn,
    csc_matrix_pipe_if.slave   bus
);

    localparam logic signed [CW-1:0] C_ONE = CW'(identity_coef(CW, FRAC));

    logic signed [CW-1:0] r_shadow [NUM_COEF];
    logic signed [CW-1:0] r_active [NUM_COEF];
    logic                 r_pending;
    logic                 r_vs_prev;
    logic                 w_commit;
    logic                 w_wr_ok;

    logic [DW-1:0]        r_din0, r_din1, r_din2;
    logic                 r_byp;
    logic [2:0]           r_sync [LAT];

    logic signed [DW:0]   w_off0, w_off1, w_off2;
    logic [DW-1:0]        w_dout0, w_dout1, w_dout2;

    function automatic logic signed [CW-1:0] reset_val(input int idx);
        return (idx == int'(ADDR_M00) || idx == int'(ADDR_M11) || idx == int'(ADDR_M22))
               ? C_ONE : '0;
    endfunction

    assign w_wr_ok  = bus.coef_wr && (bus.coef_addr < 4'(NUM_COEF));
    assign w_commit = bus.vsync_in && !r_vs_prev && r_pending;

    // Shadow bank and pending flag; a write in the commit cycle keeps pending set.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_COEF; i++) begin
                r_shadow[i] <= reset_val(i);
            end
            r_pending <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_shadow[bus.coef_addr] <= bus.coef_wdata;
            end
            if (w_wr_ok) begin
                r_pending <= 1'b1;
            end else if (w_commit) begin
                r_pending <= 1'b0;
            end
        end
    end

    // Active bank only changes on a frame-start commit; it copies the pre-write shadow.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_COEF; i++) begin
                r_active[i] <= reset_val(i);
            end
        end else if (w_commit) begin
            for (int i = 0; i < NUM_COEF; i++) begin
                r_active[i] <= r_shadow[i];
            end
        end
    end

    // Previous vsync level for rising-edge detection.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_vs_prev <= 1'b0;
        end else begin
            r_vs_prev <= bus.vsync_in;
        end
    end

    // S1: register components and the per-pixel bypass flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_din0 <= '0;
            r_din1 <= '0;
            r_din2 <= '0;
            r_byp  <= 1'b0;
        end else begin
            r_din0 <= bus.din0;
            r_din1 <= bus.din1;
            r_din2 <= bus.din2;
            r_byp  <= bus.bypass;
        end
    end

    // Sync/de delay line, LAT stages deep to line up with the datapath.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < LAT; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= {bus.hsync_in, bus.vsync_in, bus.de_in};
            for (int i = 1; i < LAT; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    // Offsets are the low DW+1 bits of the stored word, signed.
    assign w_off0 = $signed(r_active[ADDR_OFF0][DW:0]);
    assign w_off1 = $signed(r_active[ADDR_OFF1][DW:0]);
    assign w_off2 = $signed(r_active[ADDR_OFF2][DW:0]);

    csc_dot3 #(.DW(DW), .CW(CW), .FRAC(FRAC)) u_row0 (
        .clk    (clk),
        .rstn   (rstn),
        .i_din0 (r_din0),
        .i_din1 (r_din1),
        .i_din2 (r_din2),
        .i_m0   (r_active[ADDR_M00]),
        .i_m1   (r_active[ADDR_M01]),
        .i_m2   (r_active[ADDR_M02]),
        .i_off  (w_off0),
        .i_byp  (r_byp),
        .i_bdin (r_din0),
        .o_dout (w_dout0)
    );

    csc_dot3 #(.DW(DW), .CW(CW), .FRAC(FRAC)) u_row1 (
        .clk    (clk),
        .rstn   (rstn),
        .i_din0 (r_din0),
        .i_din1 (r_din1),
        .i_din2 (r_din2),
        .i_m0   (r_active[ADDR_M10]),
        .i_m1   (r_active[ADDR_M11]),
        .i_m2   (r_active[ADDR_M12]),
        .i_off  (w_off1),
        .i_byp  (r_byp),
        .i_bdin (r_din1),
        .o_dout (w_dout1)
    );

    csc_dot3 #(.DW(DW), .CW(CW), .FRAC(FRAC)) u_row2 (
        .clk    (clk),
        .rstn   (rstn),
        .i_din0 (r_din0),
        .i_din1 (r_din1),
        .i_din2 (r_din2),
        .i_m0   (r_active[ADDR_M20]),
        .i_m1   (r_active[ADDR_M21]),
        .i_m2   (r_active[ADDR_M22]),
        .i_off  (w_off2),
        .i_byp  (r_byp),
        .i_bdin (r_din2),
        .o_dout (w_dout2)
    );

    assign bus.dout0        = w_dout0;
    assign bus.dout1        = w_dout1;
    assign bus.dout2        = w_dout2;
    assign bus.hsync_out    = r_sync[LAT-1][2];
    assign bus.vsync_out    = r_sync[LAT-1][1];
    assign bus.de_out       = r_sync[LAT-1][0];
    assign bus.coef_pending = r_pending;

endmodule

// File: tb/tb_csc_matrix_pipe.sv
// Bench for csc_matrix_pipe: directed scenarios plus randomized frames, compared against
// an arithmetic reference model of the converter (real-valued matrix maths, floor, clamp).
module tb_csc_matrix_pipe;

    localparam int DW   = 12;
    localparam int CW   = 16;
    localparam int FRAC = 12;
    localparam int DEPTH = 4;

    logic clk  = 1'b0;
    logic rstn = 1'b1;

    always #5 clk = ~clk;

    csc_matrix_pipe_if #(.DW(DW), .CW(CW)) bus ();

    csc_matrix_pipe #(.DW(DW), .CW(CW), .FRAC(FRAC)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    typedef struct {
        bit de;
        bit hs;
        bit vs;
        int d0;
        int d1;
        int d2;
        int x0;
    } exp_t;

    int   sh [12];
    int   ac [12];
    bit   pend;
    bit   vs_prev;
    exp_t q [$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic longint sext(input int v, input int bits);
        longint m;
        m = longint'(v) & ((longint'(1) << bits) - 1);
        if (m >= (longint'(1) << (bits - 1))) m = m - (longint'(1) << bits);
        return m;
    endfunction

    // out = clamp(round_half_up(sum(d*m)/2^FRAC + offset))
    function automatic int row_out(input int r, input int d0, input int d1, input int d2);
        longint one, num, y;
        one = longint'(1) << FRAC;
        num = longint'(d0) * sext(ac[3*r], CW) + longint'(d1) * sext(ac[3*r+1], CW)
            + longint'(d2) * sext(ac[3*r+2], CW) + sext(ac[9+r], DW+1) * one + one / 2;
        y = num / one;
        if ((num % one) != 0 && num < 0) y = y - 1;
        if (y < 0) y = 0;
        if (y > (1 << DW) - 1) y = (1 << DW) - 1;
        return int'(y);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 12; i++) begin
            sh[i] = (i == 0 || i == 4 || i == 8) ? (1 << FRAC) : 0;
            ac[i] = sh[i];
        end
        pend    = 1'b0;
        vs_prev = 1'b0;
    endfunction

    // One clock: drive inputs, update the model, then compare the pixel that entered DEPTH cycles ago.
    task automatic step(input int d0, input int d1, input int d2, input bit de, input bit vs,
                        input bit byp, input bit wr, input int addr, input int wdata, input int x0);
        exp_t e;
        e.hs = 1'($urandom_range(0, 1));
        bus.din0       = DW'(d0);
        bus.din1       = DW'(d1);
        bus.din2       = DW'(d2);
        bus.de_in      = de;
        bus.hsync_in   = e.hs;
        bus.vsync_in   = vs;
        bus.bypass     = byp;
        bus.coef_wr    = wr;
        bus.coef_addr  = 4'(addr);
        bus.coef_wdata = CW'(wdata);

        if (vs && !vs_prev && pend) begin
            ac   = sh;
            pend = 1'b0;
        end
        e.de = de;
        e.vs = vs;
        e.x0 = x0;
        e.d0 = byp ? d0 : row_out(0, d0, d1, d2);
        e.d1 = byp ? d1 : row_out(1, d0, d1, d2);
        e.d2 = byp ? d2 : row_out(2, d0, d1, d2);
        if (wr && addr < 12) begin
            sh[addr] = wdata & ((1 << CW) - 1);
            pend     = 1'b1;
        end
        vs_prev = vs;
        q.push_back(e);

        @(posedge clk);
        #1;
        check_val("coef_pending", bus.coef_pending, pend);
        if (q.size() == DEPTH) begin
            e = q.pop_front();
            check_val("de_out", bus.de_out, e.de);
            check_val("hsync_out", bus.hsync_out, e.hs);
            check_val("vsync_out", bus.vsync_out, e.vs);
            if (e.de) begin
                check_val("dout0", bus.dout0, e.d0);
                check_val("dout1", bus.dout1, e.d1);
                check_val("dout2", bus.dout2, e.d2);
            end
            if (e.x0 >= 0) check_val("literal_dout0", bus.dout0, e.x0);
        end
    endtask

    task automatic do_reset();
        exp_t z;
        rstn = 1'b0;
        bus.din0 = '0; bus.din1 = '0; bus.din2 = '0;
        bus.de_in = 1'b0; bus.hsync_in = 1'b0; bus.vsync_in = 1'b0; bus.bypass = 1'b0;
        bus.coef_wr = 1'b0; bus.coef_addr = '0; bus.coef_wdata = '0;
        #1;
        check_val("rst_dout0", bus.dout0, 0);
        check_val("rst_dout1", bus.dout1, 0);
        check_val("rst_dout2", bus.dout2, 0);
        check_val("rst_syncs", {bus.hsync_out, bus.vsync_out, bus.de_out}, 0);
        check_val("rst_pending", bus.coef_pending, 0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        model_reset();
        q.delete();
        z = '{de: 1'b0, hs: 1'b0, vs: 1'b0, d0: 0, d1: 0, d2: 0, x0: -1};
        repeat (DEPTH - 1) q.push_back(z);
    endtask

    function automatic int rnd_px();
        return int'($urandom_range(0, (1 << DW) - 1));
    endfunction

    task automatic px(input int d0, input int d1, input int d2, input bit byp, input int x0);
        step(d0, d1, d2, 1'b1, 1'b0, byp, 1'b0, 0, 0, x0);
    endtask

    task automatic rand_px();
        step(rnd_px(), rnd_px(), rnd_px(), 1'($urandom_range(0, 1)), 1'b0,
             1'($urandom_range(0, 3) == 0), 1'b0, 0, 0, -1);
    endtask

    task automatic wr_coef(input int addr, input int data);
        step(rnd_px(), rnd_px(), rnd_px(), 1'b1, 1'b0, 1'b0, 1'b1, addr, data, -1);
    endtask

    // Blanking around the vsync rise; an optional write lands on the rise cycle itself.
    task automatic frame_start(input bit wr, input int addr, input int data);
        step(rnd_px(), rnd_px(), rnd_px(), 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, -1);
        step(rnd_px(), rnd_px(), rnd_px(), 1'b0, 1'b1, 1'b0, wr, addr, data, -1);
        step(rnd_px(), rnd_px(), rnd_px(), 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, -1);
        step(rnd_px(), rnd_px(), rnd_px(), 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, -1);
    endtask

    function automatic int rnd_coef(input int addr);
        int v;
        if (addr >= 9) begin
            v = int'($urandom_range(0, 400)) - 200;
        end else if ($urandom_range(0, 3) == 0) begin
            v = int'($urandom_range(0, 65535));
        end else begin
            v = int'($urandom_range(0, 'h1800)) - 'h0C00;
        end
        return v & 'hFFFF;
    endfunction

    initial begin
        do_reset();

        // Identity after reset
        px(100, 200, 300, 1'b0, 100);
        repeat (8) rand_px();

        // Deferred commit of row 0 = 0.25 each
        wr_coef(0, 'h0400);
        wr_coef(1, 'h0400);
        wr_coef(2, 'h0400);
        px(400, 800, 1200, 1'b0, 400);
        px(400, 800, 1200, 1'b0, 400);
        frame_start(1'b0, 0, 0);
        px(400, 800, 1200, 1'b0, 600);

        // Saturation high, low and with offset
        wr_coef(0, 'h2000);
        frame_start(1'b0, 0, 0);
        px(3000, 0, 0, 1'b0, 4095);
        wr_coef(0, 'hF000);
        frame_start(1'b0, 0, 0);
        px(5, 0, 0, 1'b0, 0);
        wr_coef(0, 'h1000);
        wr_coef(9, 100);
        frame_start(1'b0, 0, 0);
        px(4090, 0, 0, 1'b0, 4095);

        // Rounding half-up and negative half
        wr_coef(0, 'h0800);
        wr_coef(9, 0);
        frame_start(1'b0, 0, 0);
        px(3, 0, 0, 1'b0, 2);
        px(2, 0, 0, 1'b0, 1);
        wr_coef(0, 'h1000);
        wr_coef(9, 'h1FFF);
        frame_start(1'b0, 0, 0);
        px(0, 0, 0, 1'b0, 0);
        px(1, 0, 0, 1'b0, 0);

        // Bypass window under a non-identity matrix
        for (int i = 0; i < 12; i++) wr_coef(i, rnd_coef(i));
        frame_start(1'b0, 0, 0);
        for (int i = 0; i < 30; i++) begin
            int d0;
            bit b;
            d0 = rnd_px();
            b  = (i >= 10 && i <= 19);
            px(d0, rnd_px(), rnd_px(), b, b ? d0 : -1);
        end

        // Ignored addresses leave pending clear
        for (int a = 12; a < 16; a++) wr_coef(a, 'h1234);

        // Write colliding with the vsync rise
        wr_coef(0, 'h1000);
        frame_start(1'b1, 0, 'h0C00);
        repeat (4) rand_px();
        frame_start(1'b0, 0, 0);
        repeat (4) rand_px();

        // Reset mid-frame with a pending write
        wr_coef(4, 'h3000);
        repeat (3) rand_px();
        do_reset();
        px(100, 200, 300, 1'b0, 100);
        repeat (3) rand_px();

        // Randomized frames
        for (int f = 0; f < 8; f++) begin
            repeat ($urandom_range(1, 6)) begin
                int a;
                a = int'($urandom_range(0, 15));
                wr_coef(a, rnd_coef(a));
            end
            if ($urandom_range(0, 1) == 1) begin
                int a;
                a = int'($urandom_range(0, 11));
                frame_start(1'b1, a, rnd_coef(a));
            end else begin
                frame_start(1'b0, 0, 0);
            end
            for (int i = 0; i < 40; i++) begin
                if ($urandom_range(0, 9) == 0) begin
                    int a;
                    a = int'($urandom_range(0, 11));
                    wr_coef(a, rnd_coef(a));
                end else begin
                    rand_px();
                end
            end
        end

        repeat (DEPTH) step(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, -1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
